lru_unique_history: RTL and testbench

- Parametrised successor to the unique-value history buffer: keeps up to HISTORY_L distinct values, most-recent first.
- Adds an insert strobe, move-to-front on re-insert, and a registered lookup port.
- Adds erase-by-value with compaction, flush, and an occupancy count.
- Sits beside address/ID trackers that need "recently seen" filtering without duplicates.

---
 rtl/lru_unique_history_pkg.sv | 24 ++
 rtl/lru_unique_history_match.sv | 41 ++++
 rtl/onehot_enc.sv | 27 ++
 rtl/lru_unique_history.sv | 213 +++++++++++++++++++++
 tb/tb_lru_unique_history.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lru_unique_history_pkg.sv
// Shared definitions for the unique-value LRU history.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package lru_unique_history_pkg;

    // Width of a position index into an L-entry history (never below 1 bit).
    function automatic int pos_w(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

    // Width of an occupancy count that must be able to hold the value L.
    function automatic int cnt_w(input int l);
        return $clog2(l + 1);
    endfunction

    // Operation selected for the current cycle, already priority-resolved.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FLUSH = 2'd1,
        OP_INS   = 2'd2,
        OP_ERS   = 2'd3
    } op_e;

endpackage

// File: rtl/lru_unique_history_match.sv
// Parallel valid-gated key compare against every history entry.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_key     value to look for
//   i_data    entry array, index 0 = newest
//   i_valid   entry valid bits
//   o_onehot  per-entry match vector (at most one bit set, entries are unique)
//   o_hit     any entry matched
//   o_pos     matched position, 0 on miss
module history_match #(
    parameter int DATA_W    = 8,
    parameter int HISTORY_L = 4,
    parameter int POS_W     = 2
) (
    input  logic [DATA_W-1:0]                 i_key,
    input  logic [HISTORY_L-1:0][DATA_W-1:0]  i_data,
    input  logic [HISTORY_L-1:0]              i_valid,
    output logic [HISTORY_L-1:0]              o_onehot,
    output logic                              o_hit,
    output logic [POS_W-1:0]                  o_pos
);

    always_comb begin
        for (int i = 0; i < HISTORY_L; i++) begin
            o_onehot[i] = i_valid[i] && (i_data[i] == i_key);
        end
    end

    assign o_hit = |o_onehot;

    onehot_enc #(
        .N (HISTORY_L),
        .W (POS_W)
    ) u_enc (
        .i_onehot (o_onehot),
        .o_pos    (o_pos)
    );

endmodule

// File: rtl/onehot_enc.sv
// One-hot to binary position encoder.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_onehot  one-hot (or all-zero) input vector
//   o_pos     index of the set bit; 0 when no bit is set
module onehot_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_pos
);

    // OR-reduction of the indices of set bits; correct as long as at most
    // one bit is set, and yields 0 for an all-zero input.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) begin
                o_pos = o_pos | W'(i);
            end
        end
    end

endmodule

// File: rtl/lru_unique_history.sv
// Most-recent-first history of up to HISTORY_L distinct values with
// insert/move-to-front, erase-with-compaction, flush and registered lookup.
// Latency: state, lookup and erase results all appear 1 cycle after the strobe.
// Backpressure: none; an erase colliding with insert/flush is dropped (ers_done=0) and must be retried.
//
// Optional feature: define LRU_UNIQUE_HISTORY_EVICT_OUT_EN to add evict_valid /
// evict_data, which report the oldest value dropped by an insert into a full history.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   ins_valid / ins_data         insert (or move-to-front) a value
//   ers_valid / ers_data         erase a value if present
//   flush                        invalidate every entry, data left in place
//   qry_valid / qry_data         lookup, answered on qry_done/qry_hit/qry_pos
//   ers_done / ers_found         result of an accepted erase
//   data_out / valid_out / count entry array (0 = newest), thermometer valid, occupancy
module lru_unique_history
    import lru_unique_history_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int HISTORY_L = 4,
    localparam int CNT_W     = cnt_w(HISTORY_L),
    localparam int POS_W     = pos_w(HISTORY_L)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              ins_valid,
    input  logic [DATA_W-1:0]                 ins_data,
    input  logic                              ers_valid,
    input  logic [DATA_W-1:0]                 ers_data,
    input  logic                              flush,
    input  logic                              qry_valid,
    input  logic [DATA_W-1:0]                 qry_data,
    output logic                              qry_done,
    output logic                              qry_hit,
    output logic [POS_W-1:0]                  qry_pos,
    output logic                              ers_done,
    output logic                              ers_found,
    output logic [HISTORY_L-1:0][DATA_W-1:0]  data_out,
    output logic [HISTORY_L-1:0]              valid_out,
    output logic [CNT_W-1:0]                  count
`ifdef LRU_UNIQUE_HISTORY_EVICT_OUT_EN
    ,
    output logic                              evict_valid,
    output logic [DATA_W-1:0]                 evict_data
`endif
);

    logic [HISTORY_L-1:0][DATA_W-1:0] r_data;
    logic [HISTORY_L-1:0]             r_valid;
    logic [CNT_W-1:0]                 r_count;
    logic                             r_qry_done;
    logic                             r_qry_hit;
    logic [POS_W-1:0]                 r_qry_pos;
    logic                             r_ers_done;
    logic                             r_ers_found;

    op_e                              w_op;
    logic [DATA_W-1:0]                w_key;
    logic [HISTORY_L-1:0]             w_key_oh;
    logic                             w_key_hit;
    logic [POS_W-1:0]                 w_key_pos;
    logic [HISTORY_L-1:0]             w_qry_oh;
    logic                             w_qry_hit;
    logic [POS_W-1:0]                 w_qry_pos;
    logic                             w_full;
    logic [HISTORY_L-1:0][DATA_W-1:0] w_data_nxt;
    logic [HISTORY_L-1:0]             w_valid_nxt;
    logic [CNT_W-1:0]                 w_count_nxt;
    logic                             w_unused;

    // Priority resolution: flush > insert > erase.
    always_comb begin
        if (flush) begin
            w_op = OP_FLUSH;
        end else if (ins_valid) begin
            w_op = OP_INS;
        end else if (ers_valid) begin
            w_op = OP_ERS;
        end else begin
            w_op = OP_NONE;
        end
    end

    // Insert and erase never take effect together, so one matcher serves both.
    assign w_key  = ins_valid ? ins_data : ers_data;
    assign w_full = (r_count == CNT_W'(HISTORY_L));

    history_match #(
        .DATA_W    (DATA_W),
        .HISTORY_L (HISTORY_L),
        .POS_W     (POS_W)
    ) u_key_match (
        .i_key    (w_key),
        .i_data   (r_data),
        .i_valid  (r_valid),
        .o_onehot (w_key_oh),
        .o_hit    (w_key_hit),
        .o_pos    (w_key_pos)
    );

    history_match #(
        .DATA_W    (DATA_W),
        .HISTORY_L (HISTORY_L),
        .POS_W     (POS_W)
    ) u_qry_match (
        .i_key    (qry_data),
        .i_data   (r_data),
        .i_valid  (r_valid),
        .o_onehot (w_qry_oh),
        .o_hit    (w_qry_hit),
        .o_pos    (w_qry_pos)
    );

    // The one-hot vectors are not needed here; positions are compared directly.
    assign w_unused = ^w_key_oh ^ ^w_qry_oh;

    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        unique case (w_op)
            OP_FLUSH: begin
                w_valid_nxt = '0;
                w_count_nxt = '0;
            end
            OP_INS: begin
                // Miss: everything shifts down one slot. Hit at p: only 0..p-1
                // shift, which overwrites the old copy at p (p=0 is a no-op).
                w_data_nxt[0] = ins_data;
                for (int i = 1; i < HISTORY_L; i++) begin
                    if (!w_key_hit || (i <= int'(w_key_pos))) begin
                        w_data_nxt[i] = r_data[i-1];
                    end
                end
                if (!w_key_hit) begin
                    w_valid_nxt = {r_valid[HISTORY_L-2:0], 1'b1};
                    if (!w_full) begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                end
            end
            OP_ERS: begin
                // Close the gap at p by pulling newer-than-oldest entries up;
                // the thermometer valid loses its top bit.
                if (w_key_hit) begin
                    for (int i = 0; i < HISTORY_L - 1; i++) begin
                        if (i >= int'(w_key_pos)) begin
                            w_data_nxt[i] = r_data[i+1];
                        end
                    end
                    w_valid_nxt = r_valid >> 1;
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= '0;
            r_count     <= '0;
            r_qry_done  <= 1'b0;
            r_qry_hit   <= 1'b0;
            r_qry_pos   <= '0;
            r_ers_done  <= 1'b0;
            r_ers_found <= 1'b0;
        end else begin
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_count     <= w_count_nxt;
            // Lookup sees the pre-update array regardless of other operations.
            r_qry_done  <= qry_valid;
            r_qry_hit   <= qry_valid && w_qry_hit;
            r_qry_pos   <= (qry_valid && w_qry_hit) ? w_qry_pos : '0;
            r_ers_done  <= (w_op == OP_ERS);
            r_ers_found <= (w_op == OP_ERS) && w_key_hit;
        end
    end

`ifdef LRU_UNIQUE_HISTORY_EVICT_OUT_EN
    logic              r_evict_valid;
    logic [DATA_W-1:0] r_evict_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_evict_valid <= 1'b0;
            r_evict_data  <= '0;
        end else begin
            r_evict_valid <= (w_op == OP_INS) && !w_key_hit && w_full;
            if ((w_op == OP_INS) && !w_key_hit && w_full) begin
                r_evict_data <= r_data[HISTORY_L-1];
            end
        end
    end

    assign evict_valid = r_evict_valid;
    assign evict_data  = r_evict_data;
`endif

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign count     = r_count;
    assign qry_done  = r_qry_done;
    assign qry_hit   = r_qry_hit;
    assign qry_pos   = r_qry_pos;
    assign ers_done  = r_ers_done;
    assign ers_found = r_ers_found;

endmodule

// File: tb/tb_lru_unique_history.sv
// Scoreboard bench for lru_unique_history (DATA_W=8, HISTORY_L=4).
// A queue-based reference list predicts each cycle's outputs at drive time;
// the prediction is popped and compared one clock later.
module tb_lru_unique_history;

    localparam int DW = 8;
    localparam int L  = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 ins_valid = 1'b0;
    logic [DW-1:0]        ins_data = '0;
    logic                 ers_valid = 1'b0;
    logic [DW-1:0]        ers_data = '0;
    logic                 flush = 1'b0;
    logic                 qry_valid = 1'b0;
    logic [DW-1:0]        qry_data = '0;
    logic                 qry_done;
    logic                 qry_hit;
    logic [1:0]           qry_pos;
    logic                 ers_done;
    logic                 ers_found;
    logic [L-1:0][DW-1:0] data_out;
    logic [L-1:0]         valid_out;
    logic [2:0]           count;
`ifdef LRU_UNIQUE_HISTORY_EVICT_OUT_EN
    logic                 evict_valid;
    logic [DW-1:0]        evict_data;
`endif

    lru_unique_history #(
        .DATA_W    (DW),
        .HISTORY_L (L)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .ers_valid (ers_valid),
        .ers_data  (ers_data),
        .flush     (flush),
        .qry_valid (qry_valid),
        .qry_data  (qry_data),
        .qry_done  (qry_done),
        .qry_hit   (qry_hit),
        .qry_pos   (qry_pos),
        .ers_done  (ers_done),
        .ers_found (ers_found),
        .data_out  (data_out),
        .valid_out (valid_out),
`ifdef LRU_UNIQUE_HISTORY_EVICT_OUT_EN
        .count       (count),
        .evict_valid (evict_valid),
        .evict_data  (evict_data)
`else
        .count     (count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [L-1:0][DW-1:0] d;
        int                   n;
        bit                   zero_all;
        bit                   qd;
        bit                   qh;
        int                   qp;
        bit                   ed;
        bit                   ef;
        bit                   ev;
        logic [DW-1:0]        evd;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m[$];      // reference list, newest first
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input logic [DW-1:0] v);
        for (int i = 0; i < m.size(); i++) begin
            if (m[i] == v) return i;
        end
        return -1;
    endfunction

    // Drive one cycle of stimulus and queue the prediction for the next edge.
    task automatic step(input bit rst, input bit iv, input logic [DW-1:0] id,
                        input bit ev, input logic [DW-1:0] ed, input bit fl,
                        input bit qv, input logic [DW-1:0] qd);
        exp_t e;
        int   p;
        @(negedge clock);
        reset     = rst;
        ins_valid = iv;
        ins_data  = id;
        ers_valid = ev;
        ers_data  = ed;
        flush     = fl;
        qry_valid = qv;
        qry_data  = qd;

        p          = find(qd);
        e.qd       = qv;
        e.qh       = qv && (p >= 0);
        e.qp       = (qv && p >= 0) ? p : 0;
        e.ed       = 1'b0;
        e.ef       = 1'b0;
        e.ev       = 1'b0;
        e.evd      = '0;
        e.zero_all = 1'b0;
        if (rst) begin
            m.delete();
            e.qd = 1'b0;
            e.qh = 1'b0;
            e.qp = 0;
            e.zero_all = 1'b1;
        end else if (fl) begin
            m.delete();
        end else if (iv) begin
            p = find(id);
            if (p >= 0) begin
                m.delete(p);
            end else if (m.size() == L) begin
                e.ev  = 1'b1;
                e.evd = m[L-1];
                void'(m.pop_back());
            end
            m.push_front(id);
        end else if (ev) begin
            e.ed = 1'b1;
            p = find(ed);
            if (p >= 0) begin
                e.ef = 1'b1;
                m.delete(p);
            end
        end
        e.n = m.size();
        e.d = '0;
        for (int i = 0; i < m.size(); i++) e.d[i] = m[i];
        sb.push_back(e);
    endtask

    task automatic ins(input logic [DW-1:0] v);
        step(0, 1, v, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic ers(input logic [DW-1:0] v);
        step(0, 0, 8'h00, 1, v, 0, 0, 8'h00);
    endtask

    task automatic qry(input logic [DW-1:0] v);
        step(0, 0, 8'h00, 0, 8'h00, 0, 1, v);
    endtask

    // Output checker: compares one queued prediction per clock, #1 after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("count", 32'(count), 32'(e.n));
                check("valid_out", 32'(valid_out), 32'((1 << e.n) - 1));
                for (int i = 0; i < L; i++) begin
                    if (i < e.n || e.zero_all) begin
                        check($sformatf("data_out[%0d]", i), 32'(data_out[i]), 32'(e.d[i]));
                    end
                end
                check("qry_done", 32'(qry_done), 32'(e.qd));
                check("qry_hit", 32'(qry_hit), 32'(e.qh));
                check("qry_pos", 32'(qry_pos), 32'(e.qp));
                check("ers_done", 32'(ers_done), 32'(e.ed));
                check("ers_found", 32'(ers_found), 32'(e.ef));
`ifdef LRU_UNIQUE_HISTORY_EVICT_OUT_EN
                check("evict_valid", 32'(evict_valid), 32'(e.ev));
                if (e.ev || e.zero_all) begin
                    check("evict_data", 32'(evict_data), 32'(e.evd));
                end
`endif
            end
        end
    end

    initial begin
        // Reset state.
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        // Erase on an empty history.
        ers(8'h05);
        // Fill, move-to-front, overflow.
        ins(8'h11);
        ins(8'h22);
        ins(8'h33);
        ins(8'h11);
        ins(8'h44);
        ins(8'h55);
        // Hit at position 0 leaves the array unchanged.
        ins(8'h55);
        // Erase hit with compaction, then erase miss.
        ers(8'h44);
        ers(8'h99);
        // Lookup concurrent with a move-to-front of the same value.
        step(0, 1, 8'h33, 0, 8'h00, 0, 1, 8'h33);
        qry(8'h33);
        qry(8'h77);
        // Flush wins over insert.
        step(0, 1, 8'h66, 0, 8'h00, 1, 0, 8'h00);
        ins(8'h01);
        // Insert wins over erase; the erase is dropped.
        step(0, 1, 8'h02, 1, 8'h01, 0, 0, 8'h00);
        qry(8'h01);
        // Reset with lookups pending.
        step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h02);
        step(1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h02);
        // Randomised mix over a small value range to force frequent hits.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 2) != 0, 8'($urandom_range(1, 7)),
                 $urandom_range(0, 1) == 1, 8'($urandom_range(1, 7)),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1, 8'($urandom_range(1, 7)));
        end
        step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
